i2c_apb_regs: RTL
=================

Name: i2c_apb_regs

Overview:
Parametrised second-generation APB register file for the I2C controller. Sits between the APB bus and the I2C core/FIFOs and holds control, address, timing and interrupt state. Adds the following over the first generation:
- proper APB PREADY/PSLVERR handshake with a registered-read wait state
- FIFO-aware error responses
- per-bit level/edge interrupt modes
- parametrised FIFO depth, interrupt count, timing width and soft-reset length

Parameters:
ADDR_W, 9, APB address width; decode uses paddr[8:0], upper bits ignored
FIFO_AW, 4, FIFO address width; occupancy fields are FIFO_AW+1 bits; full = 2**FIFO_AW
NIRQ, 8, number of interrupt sources (1..32)
TIMING_W, 32, width of the eight timing registers (1..32)
SRST_CYC, 10, soft-reset pulse length in clk cycles (1..15)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
psel, penable, pwrite  in  1  APB control
paddr  in  ADDR_W  APB address
pwdata  in  32  APB write data
prdata  out  32  APB read data, registered
pready  out  1  APB ready
pslverr  out  1  APB error, valid when pready=1
irq  out  1  interrupt to system
tx_fifo_ocy, rx_fifo_ocy  in  FIFO_AW+1  FIFO occupancy
tx_fifo_wr  out  1  TX push strobe
tx_fifo_wdat  out  10  TX push data = pwdata[9:0]
rx_fifo_rd  out  1  RX pop strobe
rx_fifo_rdat  in  8  RX head data, fall-through
rx_fifo_pirq  out  FIFO_AW+1  RX programmable threshold
slv_adr  out  10  {ten_adr[2:0], adr[6:0]}
srstn  out  1  soft reset to core, active low
cr  out  7  control register
cr_set, cr_clr  in  7  hardware set/clear of cr
sr  in  8  status, read-only
irq_req  in  NIRQ  interrupt sources
tsusta, tsusto, thdsta, tsudat, tbuf, thigh, tlow, thddat  out  TIMING_W  bus timing

Behaviour:
Reset (rstn low, async) values:
- prdata 0, pready 0, pslverr 0, srstn 1, cr 0, gie 0, isr/ier/imode 0
- adr 0, ten_adr 0, rx_pirq 1
- tsusta 0x23a, tsusto 0x1f4, thdsta 0x1ae, tsudat 0x100, tbuf 0x1f4, thigh 0x1ed, tlow 0x1ed, thddat 0x40 (each truncated to TIMING_W)
- FSM returns to IDLE

Handshake FSM, states IDLE, WAIT:
- Write access (psel&penable&pwrite in IDLE): pready=1 that cycle, zero wait. Register update on that edge.
- Read access in IDLE: pready=0; prdata and pslverr are captured at the edge; FSM goes to WAIT. In WAIT, pready=1 and FSM returns to IDLE.
- Each read therefore completes in exactly one wait state.
- pready is combinational from state; pready=0 whenever psel=0.

Register map:
- 0x01C GIE[31]
- 0x020 ISR W1C
- 0x028 IER
- 0x02C IMODE: 1 = edge, 0 = level
- 0x040 SOFTR (write only)
- 0x100 CR
- 0x104 SR (read only)
- 0x108 TXD (write only, reads 0)
- 0x10C RXD
- 0x110 ADR[7:1]
- 0x114 TXOCY (read only)
- 0x118 RXOCY (read only)
- 0x11C TEN_ADR[2:0]
- 0x120 RX_PIRQ
- 0x128–0x144 timing registers in port order
- Unused read bits return 0.

Errors (pslverr=1 on the completing cycle):
- Unmapped address: read data 0xdeadbeef; write is ignored.
- TXD write while tx_fifo_ocy == 2**FIFO_AW: no push.
- RXD read while rx_fifo_ocy == 0: no pop, prdata 0.
- Writes to read-only registers are ignored and raise no error.

FIFO strobes:
- tx_fifo_wr is a 1-cycle pulse on an accepted TXD write.
- rx_fifo_rd is a 1-cycle pulse in the IDLE access cycle of an RXD read, concurrent with capturing rx_fifo_rdat. Exactly one pop per transfer.

CR:
- An APB write to CR wins over hardware.
- Otherwise cr <= (cr | cr_set) & ~cr_clr; clear wins over set.

ISR:
- Source event per bit: level mode = irq_req; edge mode = irq_req & ~irq_req_q (the previous-cycle copy, reset 0).
- isr <= (isr & ~w1c) | event; a set wins over a simultaneous W1C.
- irq = gie & |(isr & ier), combinational.

Soft reset:
- Writing 0x0000000A to SOFTR drives srstn low on the next edge for exactly SRST_CYC cycles.
- A write during an active pulse reloads the counter and extends the pulse.
- Any other value is ignored.
- srstn does not reset this block.

Test Plan:
- Reset, then read all registers → tlow 0x1ed, rx_pirq 1, cr 0. Each read shows pready low for 1 cycle, then high with pslverr 0.
- Write TXD 0x2A5 with tx_fifo_ocy=3 → tx_fifo_wr single pulse, tx_fifo_wdat 0x2A5. Repeat with ocy=16 (FIFO_AW=4) → no pulse, pslverr=1.
- RXD read with rx_fifo_ocy=2, rdat 0x5C → prdata 0x5C, exactly one rx_fifo_rd pulse. With ocy=0 → no pulse, prdata 0, pslverr=1.
- IMODE[0]=1, IER=1, GIE=1, hold irq_req[0] high for 5 cycles → isr[0] set once, irq=1. W1C 0x1 → isr[0]=0 while irq_req stays high. Repeat in level mode → isr[0] re-sets the next cycle.
- Write SOFTR=0xA → srstn low 10 cycles. Rewrite at cycle 6 → low 16 cycles total. Write 0xB → no effect.
- Assert cr_set[0] and cr_clr[0] together → cr[0]=0. APB write CR=0x7F concurrent with cr_clr=0x7F → cr=0x7F. Assert rstn mid-read (WAIT) → pready 0, FSM IDLE.

Source files
------------

// File: rtl/i2c_apb_regs.sv
// APB register file for the I2C controller: control, address, timing and interrupt state,
// FIFO push/pop strobes and a soft-reset pulse generator for the core.
module i2c_apb_regs #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned FIFO_AW  = 4,
  parameter int unsigned NIRQ     = 8,
  parameter int unsigned TIMING_W = 32,
  parameter int unsigned SRST_CYC = 10
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [31:0]         pwdata,
  output logic [31:0]         prdata,
  output logic                pready,
  output logic                pslverr,
  output logic                irq,
  input  logic [FIFO_AW:0]    tx_fifo_ocy,
  input  logic [FIFO_AW:0]    rx_fifo_ocy,
  output logic                tx_fifo_wr,
  output logic [9:0]          tx_fifo_wdat,
  output logic                rx_fifo_rd,
  input  logic [7:0]          rx_fifo_rdat,
  output logic [FIFO_AW:0]    rx_fifo_pirq,
  output logic [9:0]          slv_adr,
  output logic                srstn,
  output logic [6:0]          cr,
  input  logic [6:0]          cr_set,
  input  logic [6:0]          cr_clr,
  input  logic [7:0]          sr,
  input  logic [NIRQ-1:0]     irq_req,
  output logic [TIMING_W-1:0] tsusta,
  output logic [TIMING_W-1:0] tsusto,
  output logic [TIMING_W-1:0] thdsta,
  output logic [TIMING_W-1:0] tsudat,
  output logic [TIMING_W-1:0] tbuf,
  output logic [TIMING_W-1:0] thigh,
  output logic [TIMING_W-1:0] tlow,
  output logic [TIMING_W-1:0] thddat
);

  localparam int unsigned OCY_W = FIFO_AW + 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [OCY_W-1:0] FIFO_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [31:0] BAD_DATA = 32'hdeadbeef;

  localparam logic [8:0] A_GIE   = 9'h01C;
  localparam logic [8:0] A_ISR   = 9'h020;
  localparam logic [8:0] A_IER   = 9'h028;
  localparam logic [8:0] A_IMODE = 9'h02C;
  localparam logic [8:0] A_SOFTR = 9'h040;
  localparam logic [8:0] A_CR    = 9'h100;
  localparam logic [8:0] A_SR    = 9'h104;
  localparam logic [8:0] A_TXD   = 9'h108;
  localparam logic [8:0] A_RXD   = 9'h10C;
  localparam logic [8:0] A_ADR   = 9'h110;
  localparam logic [8:0] A_TXOCY = 9'h114;
  localparam logic [8:0] A_RXOCY = 9'h118;
  localparam logic [8:0] A_TEN   = 9'h11C;
  localparam logic [8:0] A_PIRQ  = 9'h120;
  localparam logic [8:0] A_TIM0  = 9'h128;

  // Timing reset values, index 0 = tsusta ... index 7 = thddat
  localparam logic [7:0][31:0] TIM_RST = {32'h040, 32'h1ed, 32'h1ed, 32'h1f4,
                                          32'h100, 32'h1ae, 32'h1f4, 32'h23a};

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e                     state_q, state_d;
  logic [31:0]                prdata_q, prdata_d;
  logic                       rderr_q, rderr_d;
  logic [6:0]                 cr_q, cr_d;
  logic                       gie_q, gie_d;
  logic [NIRQ-1:0]            isr_q, isr_d;
  logic [NIRQ-1:0]            ier_q, ier_d;
  logic [NIRQ-1:0]            imode_q, imode_d;
  logic [NIRQ-1:0]            irq_req_q;
  logic [6:0]                 adr_q, adr_d;
  logic [2:0]                 ten_q, ten_d;
  logic [OCY_W-1:0]           pirq_q, pirq_d;
  logic [7:0][TIMING_W-1:0]   tim_q, tim_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       srstn_q, srstn_d;

  logic [8:0]                 a;
  logic [ADDR_W-1:0]          paddr_unused;
  logic                       wr_acc, rd_acc, tx_full, rx_empty;
  logic                       tim_hit, mapped, rd_err, wr_err;
  logic [2:0]                 tim_idx;
  logic [31:0]                rmux, rd_data;
  logic [NIRQ-1:0]            w1c, irq_evt;

  assign a            = paddr[8:0];
  assign paddr_unused = paddr;
  assign wr_acc   = psel & penable &  pwrite & (state_q == S_IDLE);
  assign rd_acc   = psel & penable & ~pwrite & (state_q == S_IDLE);
  assign tx_full  = (tx_fifo_ocy == FIFO_FULL);
  assign rx_empty = (rx_fifo_ocy == '0);

  // Address decode and read mux
  always_comb begin
    tim_hit = 1'b0;
    tim_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (a == 9'(32'(A_TIM0) + 32'(4 * i))) begin
        tim_hit = 1'b1;
        tim_idx = 3'(i);
      end
    end
    mapped = 1'b1;
    rmux   = '0;
    case (a)
      A_GIE:          rmux = {gie_q, 31'b0};
      A_ISR:          rmux = 32'(isr_q);
      A_IER:          rmux = 32'(ier_q);
      A_IMODE:        rmux = 32'(imode_q);
      A_SOFTR, A_TXD: rmux = '0;
      A_CR:           rmux = 32'(cr_q);
      A_SR:           rmux = 32'(sr);
      A_RXD:          rmux = 32'(rx_fifo_rdat);
      A_ADR:          rmux = 32'({adr_q, 1'b0});
      A_TXOCY:        rmux = 32'(tx_fifo_ocy);
      A_RXOCY:        rmux = 32'(rx_fifo_ocy);
      A_TEN:          rmux = 32'(ten_q);
      A_PIRQ:         rmux = 32'(pirq_q);
      default: begin
        mapped = tim_hit;
        rmux   = tim_hit ? 32'(tim_q[tim_idx]) : 32'h0;
      end
    endcase
    rd_err  = ~mapped | ((a == A_RXD) & rx_empty);
    wr_err  = ~mapped | ((a == A_TXD) & tx_full);
    rd_data = ~mapped ? BAD_DATA : (((a == A_RXD) & rx_empty) ? 32'h0 : rmux);
  end

  // Next-state logic for the handshake FSM and all registers
  always_comb begin
    state_d  = state_q;
    prdata_d = prdata_q;
    rderr_d  = rderr_q;
    gie_d    = gie_q;
    ier_d    = ier_q;
    imode_d  = imode_q;
    adr_d    = adr_q;
    ten_d    = ten_q;
    pirq_d   = pirq_q;
    tim_d    = tim_q;
    w1c      = '0;
    cr_d     = (cr_q | cr_set) & ~cr_clr;
    cnt_d    = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;

    case (state_q)
      S_IDLE: begin
        if (rd_acc) begin
          state_d  = S_WAIT;
          prdata_d = rd_data;
          rderr_d  = rd_err;
        end
      end
      S_WAIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (wr_acc && mapped) begin
      case (a)
        A_GIE:   gie_d   = pwdata[31];
        A_ISR:   w1c     = pwdata[NIRQ-1:0];
        A_IER:   ier_d   = pwdata[NIRQ-1:0];
        A_IMODE: imode_d = pwdata[NIRQ-1:0];
        A_SOFTR: if (pwdata == 32'h0000000A) cnt_d = CNT_W'(SRST_CYC);
        A_CR:    cr_d    = pwdata[6:0];
        A_ADR:   adr_d   = pwdata[7:1];
        A_TEN:   ten_d   = pwdata[2:0];
        A_PIRQ:  pirq_d  = pwdata[OCY_W-1:0];
        default: if (tim_hit) tim_d[tim_idx] = pwdata[TIMING_W-1:0];
      endcase
    end

    // Edge-mode bits only fire on a rising request; a new event beats a W1C
    irq_evt = irq_req & ~(imode_q & irq_req_q);
    isr_d   = (isr_q & ~w1c) | irq_evt;
    srstn_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      prdata_q  <= '0;
      rderr_q   <= 1'b0;
      cr_q      <= '0;
      gie_q     <= 1'b0;
      isr_q     <= '0;
      ier_q     <= '0;
      imode_q   <= '0;
      irq_req_q <= '0;
      adr_q     <= '0;
      ten_q     <= '0;
      pirq_q    <= OCY_W'(1);
      cnt_q     <= '0;
      srstn_q   <= 1'b1;
      for (int i = 0; i < 8; i++) tim_q[i] <= TIMING_W'(TIM_RST[i]);
    end else begin
      state_q   <= state_d;
      prdata_q  <= prdata_d;
      rderr_q   <= rderr_d;
      cr_q      <= cr_d;
      gie_q     <= gie_d;
      isr_q     <= isr_d;
      ier_q     <= ier_d;
      imode_q   <= imode_d;
      irq_req_q <= irq_req;
      adr_q     <= adr_d;
      ten_q     <= ten_d;
      pirq_q    <= pirq_d;
      cnt_q     <= cnt_d;
      srstn_q   <= srstn_d;
      tim_q     <= tim_d;
    end
  end

  assign pready       = psel & penable & ((state_q == S_WAIT) | pwrite);
  assign pslverr      = psel & penable & ((state_q == S_WAIT) ? rderr_q : (pwrite & wr_err));
  assign prdata       = prdata_q;
  assign irq          = gie_q & (|(isr_q & ier_q));
  assign tx_fifo_wr   = wr_acc & (a == A_TXD) & ~tx_full;
  assign tx_fifo_wdat = pwdata[9:0];
  assign rx_fifo_rd   = rd_acc & (a == A_RXD) & ~rx_empty;
  assign rx_fifo_pirq = pirq_q;
  assign slv_adr      = {ten_q, adr_q};
  assign srstn        = srstn_q;
  assign cr           = cr_q;
  assign tsusta       = tim_q[0];
  assign tsusto       = tim_q[1];
  assign thdsta       = tim_q[2];
  assign tsudat       = tim_q[3];
  assign tbuf         = tim_q[4];
  assign thigh        = tim_q[5];
  assign tlow         = tim_q[6];
  assign thddat       = tim_q[7];

endmodule
